// File: rtl/spi_iram_loader.sv
// SPI slave boot loader for the Forth CPU instruction RAM: receives 16-bit frames
// (address first, then data), writes them to iram and arbitrates the RAM write port.
module spi_iram_loader #(
   parameter int ADDR_W    = 10,
   parameter bit BOOT_HOLD = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              nCS,
   input  logic              SCK,
   input  logic              MOSI,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [15:0]       cpu_wdata,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [15:0]       ram_wdata,
   output logic              cpu_hold,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

   state_t            state;
   logic [1:0]        ncs_sync;
   logic [1:0]        sck_sync;
   logic [1:0]        mosi_sync;
   logic              ncs_d;
   logic              sck_d;
   logic [14:0]       shreg;
   logic [3:0]        bit_cnt;
   logic [ADDR_W-1:0] addr_cnt;
   logic [15:0]       wdata;
   logic              ld_we;

   logic              ncs_s;
   logic              sck_s;
   logic              mosi_s;
   logic              sck_rise;
   logic              cs_fall;
   logic              cs_rise;
   logic              shift_en;
   logic              frame_done;
   logic [15:0]       frame;

   // Synchronisers are left unreset so a reset with nCS held low does not fake a cs_fall.
   always_ff @(posedge clk) begin
      ncs_sync  <= {ncs_sync[0], nCS};
      sck_sync  <= {sck_sync[0], SCK};
      mosi_sync <= {mosi_sync[0], MOSI};
      ncs_d     <= ncs_sync[1];
      sck_d     <= sck_sync[1];
   end

   assign ncs_s      = ncs_sync[1];
   assign sck_s      = sck_sync[1];
   assign mosi_s     = mosi_sync[1];
   assign sck_rise   = sck_s & ~sck_d;
   assign cs_fall    = ~ncs_s & ncs_d;
   assign cs_rise    = ncs_s & ~ncs_d;
   assign shift_en   = sck_rise & ~ncs_s;
   assign frame_done = shift_en && (bit_cnt == 4'd15);
   assign frame      = {shreg, mosi_s};

   // Shifter, session FSM and loader write port share one register block.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         shreg    <= '0;
         bit_cnt  <= '0;
         addr_cnt <= '0;
         wdata    <= '0;
         ld_we    <= 1'b0;
         busy     <= 1'b0;
         cpu_hold <= BOOT_HOLD;
      end else begin
         ld_we <= 1'b0;
         if (shift_en) begin
            shreg   <= frame[14:0];
            bit_cnt <= bit_cnt + 4'd1;
         end
         if (ld_we) begin
            addr_cnt <= addr_cnt + 1'b1;
         end
         case (state)
            IDLE: begin
               if (cs_fall) begin
                  state    <= ADDR;
                  busy     <= 1'b1;
                  cpu_hold <= 1'b1;
                  bit_cnt  <= '0;
               end
            end
            ADDR: begin
               if (frame_done) begin
                  addr_cnt <= frame[ADDR_W-1:0];
                  state    <= DATA;
               end
               if (cs_rise) begin
                  state   <= DONE;
                  busy    <= 1'b0;
                  bit_cnt <= '0;
               end
            end
            DATA: begin
               if (frame_done) begin
                  ld_we <= 1'b1;
                  wdata <= frame;
               end
               if (cs_rise) begin
                  state   <= DONE;
                  busy    <= 1'b0;
                  bit_cnt <= '0;
               end
            end
            DONE: begin
               cpu_hold <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Loader owns the port while the CPU is held; otherwise zero-latency pass-through.
   always_comb begin
      ram_we    = cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      if (cpu_hold) begin
         ram_we    = ld_we;
         ram_addr  = addr_cnt;
         ram_wdata = wdata;
      end
   end

endmodule

// File: doc/spi_iram_loader.md
# spi_iram_loader

SPI slave boot loader and write-port arbiter for the Forth CPU instruction RAM. It receives 16-bit words over the external `nCS`/`SCK`/`MOSI` pins and writes them into iram at an auto-incrementing address. While a load session is active it holds the CPU in reset. When no session is active it passes the CPU's own RAM write port straight through. It sits in `top` between the SPI pins, `cpu_top`, and the iram write port.

## Interface
- `ADDR_W`, default 10: iram address width; the address counter wraps modulo 2^ADDR_W.
- `BOOT_HOLD`, default 1: when 1, `cpu_hold` is high from reset until the first complete session ends. When 0, `cpu_hold` is high only during sessions.
- `clk`  in  1: system clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `nCS`  in  1: SPI chip select, active low, asynchronous to `clk`.
- `SCK`  in  1: SPI clock, mode 0, asynchronous to `clk`.
- `MOSI`  in  1: SPI data, MSB first, asynchronous to `clk`.
- `cpu_we`  in  1: CPU write strobe for iram.
- `cpu_addr`  in  ADDR_W: CPU write address.
- `cpu_wdata`  in  16: CPU write data.
- `ram_we`  out  1: iram write strobe.
- `ram_addr`  out  ADDR_W: iram write address.
- `ram_wdata`  out  16: iram write data.
- `cpu_hold`  out  1: holds `cpu_top` in reset while high.
- `busy`  out  1: high while the state is ADDR or DATA.

## Operation
**Synchronisers**
- `nCS`, `SCK` and `MOSI` each pass through 2-flop synchronisers.
- A third register on the synchronised `SCK` produces a one-cycle `sck_rise` pulse.
- The same kind of register on the synchronised `nCS` produces `cs_fall` and `cs_rise` pulses.
- Constraint on the SCK source: SCK high and low phases must each be at least 3 `clk` periods.

**Shifting**
- On `sck_rise` while the synchronised `nCS` is low, the synchronised MOSI bit is shifted into a 16-bit shift register (LSB in, MSB first) and a 4-bit bit counter increments.
- When the count wraps 15→0, a complete frame is reported to the state machine.

**State machine (IDLE, ADDR, DATA, DONE)**
- IDLE → ADDR on `cs_fall`. On entry: bit counter cleared, `cpu_hold` set.
- ADDR: on a complete frame, the address counter loads frame[ADDR_W-1:0]; the upper bits are ignored. Go to DATA.
- DATA: on each complete frame:
  - the loader drives `ram_we`=1, `ram_addr`=address counter, `ram_wdata`=frame for exactly one cycle;
  - the address counter then increments, wrapping from 2^ADDR_W-1 to 0.
- ADDR or DATA → DONE on `cs_rise`. An incomplete frame is discarded and the bit counter cleared; no write is issued.
- DONE → IDLE after one cycle. In DONE, `cpu_hold` clears (this also clears the BOOT_HOLD latch).
- Any `cs_fall` seen outside IDLE is ignored.

**Arbitration**
- While `cpu_hold`=1, the loader owns the RAM port. `ram_we` is 0 except for loader writes, and `cpu_we` is ignored (dropped).
- While `cpu_hold`=0, the outputs are combinational pass-through: `ram_we`=`cpu_we`, `ram_addr`=`cpu_addr`, `ram_wdata`=`cpu_wdata`, with zero latency.

**Reset**
- State returns to IDLE.
- Shift register, bit counter and address counter are cleared to 0.
- `cpu_hold` = `BOOT_HOLD`.
- A reset during a session aborts it with no further writes.

## Timing
**Reset values**
- Registered: `ram_we`=0, `busy`=0, `cpu_hold`=BOOT_HOLD, state=IDLE.
- `ram_addr`/`ram_wdata`: 0 while held; otherwise they follow the CPU inputs.

**Latencies**
- SCK rising edge at the pin → bit sampled within 3–4 `clk` cycles.
- `sck_rise` for the 16th bit of a data frame → `ram_we` high on the next cycle, for exactly 1 cycle.
- Address counter updates in the cycle after `ram_we`.
- `nCS` rising at the pin → `cs_rise` within 3–4 cycles → DONE next cycle → `cpu_hold`=0 the following cycle.
- `busy` changes on the same cycle as the ADDR/DONE state transitions.

**Boundary cases**
- Maximum write rate: one write per 16 `sck_rise` pulses; there is no back-pressure.
- Frame completion and `cs_rise` in the same cycle: the frame write is issued first, then the FSM goes to DONE.
- Address counter wrap is silent; there is no flag.

## Test plan
- **Basic load:** reset with BOOT_HOLD=1; send address 0x0000 then 0x8003, 0x8101, 0x0DC0; raise nCS.
  - Required: writes iram[0]=0x8003, iram[1]=0x8101, iram[2]=0x0DC0, each `ram_we` exactly 1 cycle.
  - Required: `cpu_hold` high until 2 cycles after `cs_rise`, then low.
- **Address wrap:** send address 0x03FF, then data 0x1111, 0x2222.
  - Required: iram[0x3FF]=0x1111, then iram[0x000]=0x2222.
- **Partial frame:** send address 0x0010, then 9 bits of data; raise nCS.
  - Required: no `ram_we`.
  - Then a new session with address 0x0010 and data 0xABCD writes iram[0x010]=0xABCD, proving the bit counter was cleared.
- **Pass-through:** with `cpu_hold`=0, drive `cpu_we`=1, `cpu_addr`=0x100, `cpu_wdata`=0x1234.
  - Required: `ram_we`/`ram_addr`/`ram_wdata` equal the CPU inputs in the same cycle.
  - Repeat during a session: required no `ram_we`.
- **Reset mid-session:** assert `reset` after 8 bits of the second data frame.
  - Required: state IDLE, `busy`=0, `cpu_hold`=BOOT_HOLD, no write.
  - Clocking the remaining bits without a new `cs_fall` causes no write.
- **BOOT_HOLD=0:** after reset, `cpu_hold`=0.
  - `cpu_hold` rises 1 cycle after `cs_fall` is detected and clears after the session's DONE.
